// File: rtl/nios_system_nios2_qsys_0_mulx_pkg.sv
// Shared definitions for the Nios II MULX multiply sequencer.
//   - op encodings (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS)
//   - sequencer state enum
//   - accumulator / operand / partial-product widths
//   - pp_shift(): left shift applied to each partial product by issue slot
package nios_system_nios2_qsys_0_mulx_pkg;

  localparam int DATA_W = 32;
  localparam int PP_W   = 16;
  localparam int ACC_W  = 64;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIX,
    DONE
  } state_t;

  // Slot 0: lo*lo, slots 1/2: cross terms, slot 3: hi*hi.
  function automatic logic [5:0] pp_shift(input logic [1:0] sel);
    case (sel)
      2'd0:    return 6'd0;
      2'd3:    return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_nios2_qsys_0_mulx_if.sv
// Operand/result handshake bundle between the issue stage, the MULX
// sequencer and the A-stage writeback mux.
//   in_valid/in_ready  : operand handshake (src1, src2, op)
//   out_valid/out_ready: result handshake (result)
// Modports: master = requester/consumer side, slave = sequencer side.
interface nios_system_nios2_qsys_0_mulx_if;
  import nios_system_nios2_qsys_0_mulx_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [1:0]        op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/nios_system_nios2_qsys_0_mulx_pp16.sv
// Registered 16x16 unsigned multiplier, one-cycle latency, intended to map
// onto a dedicated DSP block.
//   clk     : clock
//   reset_n : synchronous active-low reset, clears p
//   a, b    : 16-bit unsigned operands
//   p       : 32-bit product of the operands presented on the previous cycle
module nios_system_nios2_qsys_0_mulx_pp16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk) begin
    if (!reset_n) p <= '0;
    else          p <= {16'd0, a} * {16'd0, b};
  end

endmodule

// File: rtl/nios_system_nios2_qsys_0_mulx_seq.sv
// Multi-cycle 32x32 multiply sequencer building the full 64-bit product from
// four 16x16 partial products, returning the high word (MULXUU/SU/SS) or the
// low word (MUL).
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of the operand/result handshake bundle
// Build option: NIOS2_MULX_SIGNED_EN enables the FIX state that applies the
// signed correction for MULXSU/MULXSS. Without it those ops run as MULXUU and
// result latency drops from 7 to 6 cycles.
module nios_system_nios2_qsys_0_mulx_seq
  import nios_system_nios2_qsys_0_mulx_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  nios_system_nios2_qsys_0_mulx_if.slave   bus
);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [1:0]         op_q;
  logic [1:0]         cnt_q;
  logic [ACC_W-1:0]   acc_q;

  logic [PP_W-1:0]    pp_a, pp_b;
  logic [2*PP_W-1:0]  pp_p;
  logic [1:0]         prev_sel;
  logic [ACC_W-1:0]   pp_shifted;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid)  state_d = ISSUE;
      ISSUE: if (cnt_q == 2'd3) state_d = DRAIN;
`ifdef NIOS2_MULX_SIGNED_EN
      DRAIN: state_d = FIX;
      FIX:   state_d = DONE;
`else
      DRAIN: state_d = DONE;
`endif
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.result    = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:DATA_W];
  end

  // Operand capture; operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) begin
      a_q <= bus.src1;
      b_q <= bus.src2;
    end
  end

  // Partial-product select for the slot issued this cycle.
  always_comb begin
    case (cnt_q)
      2'd0:    begin pp_a = a_q[15:0];  pp_b = b_q[15:0];  end
      2'd1:    begin pp_a = a_q[31:16]; pp_b = b_q[15:0];  end
      2'd2:    begin pp_a = a_q[15:0];  pp_b = b_q[31:16]; end
      default: begin pp_a = a_q[31:16]; pp_b = b_q[31:16]; end
    endcase
  end

  nios_system_nios2_qsys_0_mulx_pp16 u_pp16 (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (pp_a),
    .b       (pp_b),
    .p       (pp_p)
  );

  // pp_p belongs to the slot issued one cycle ago. cnt_q wraps 3->0 on the
  // last ISSUE cycle, so in DRAIN cnt_q-1 is 3, the hi*hi slot.
  assign prev_sel   = cnt_q - 2'd1;
  assign pp_shifted = {{(ACC_W-2*PP_W){1'b0}}, pp_p} << pp_shift(prev_sel);

`ifdef NIOS2_MULX_SIGNED_EN
  // Two's-complement correction of the unsigned product's high word.
  logic [DATA_W-1:0] corr;
  always_comb begin
    corr = '0;
    if (op_q[1] && a_q[DATA_W-1])         corr = corr + b_q;
    if (op_q == OP_MULXSS && b_q[DATA_W-1]) corr = corr + a_q;
  end
`endif

  // Accumulator, slot counter and captured op
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= 2'd0;
      op_q  <= OP_MUL;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          acc_q <= '0;
          cnt_q <= 2'd0;
        end
        ISSUE: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q != 2'd0) acc_q <= acc_q + pp_shifted;
        end
        DRAIN: acc_q <= acc_q + pp_shifted;
`ifdef NIOS2_MULX_SIGNED_EN
        FIX: acc_q[ACC_W-1:DATA_W] <= acc_q[ACC_W-1:DATA_W] - corr;
`endif
        default: ;
      endcase
    end
  end

endmodule
